// File: rtl/mips_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM states and the LO value written on a divide by zero.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } mdu_state_t;

  // LO on divide by zero; all ones for operand widths up to 32 bits
  localparam logic [31:0] MDU_DIVZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the multiply/divide loop.
// Multiply: conditional add of the multiplicand into HI, then shift {HI,LO}
// right by one so the next multiplier bit lands in LO[0].
// Divide (only with MDU_DIV_EN defined): shift {REM,Q} left by one, trial
// subtract the divisor, keep the difference and set the quotient bit when it
// does not borrow, otherwise restore.
module mdu_iter_step #(
  parameter int DATA_WIDTH = 32
) (
`ifdef MDU_DIV_EN
  input  logic                  is_div,
`endif
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] next_hi,
  output logic [DATA_WIDTH-1:0] next_lo
);

  logic [DATA_WIDTH:0] mul_sum;

  // Add the multiplicand when the current multiplier bit is set; keep the carry
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(DATA_WIDTH+1){1'b0}});
  end

`ifdef MDU_DIV_EN
  logic [DATA_WIDTH:0] div_shift;
  logic [DATA_WIDTH:0] div_trial;

  // Trial subtraction of the divisor from the partial remainder shifted left
  always_comb begin
    div_shift = {hi, lo[DATA_WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
  end
`endif

  // Select the next accumulator value for the operation in flight
  always_comb begin
    next_hi = mul_sum[DATA_WIDTH:1];
    next_lo = {mul_sum[0], lo[DATA_WIDTH-1:1]};
`ifdef MDU_DIV_EN
    if (is_div) begin
      if (div_trial[DATA_WIDTH]) begin
        next_hi = div_shift[DATA_WIDTH-1:0];
        next_lo = {lo[DATA_WIDTH-2:0], 1'b0};
      end else begin
        next_hi = div_trial[DATA_WIDTH-1:0];
        next_lo = {lo[DATA_WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU (and DIV/DIVU when MDU_DIV_EN is defined) run on unsigned
// magnitudes for DATA_WIDTH cycles, then one SIGN cycle fixes the result
// signs and writes HI/LO. MTHI/MTLO write in a single cycle from IDLE.
// Build option MDU_DIV_EN: without it DIV/DIVU are ignored like unused ops.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  mdu_state_t state;
  logic [CNT_W-1:0] iter_cnt;
  logic [DATA_WIDTH-1:0] acc_hi;
  logic [DATA_WIDTH-1:0] acc_lo;
  logic [DATA_WIDTH-1:0] operand_b;
  logic res_neg;

`ifdef MDU_DIV_EN
  logic op_div;
  logic rem_neg;
  logic div_zero;
  logic [DATA_WIDTH-1:0] rs_orig;
`endif

  logic start_mul;
  logic start_div;
  logic signed_op;
  logic write_hi;
  logic write_lo;
  logic [DATA_WIDTH-1:0] rs_mag;
  logic [DATA_WIDTH-1:0] rt_mag;
  logic [DATA_WIDTH-1:0] step_hi;
  logic [DATA_WIDTH-1:0] step_lo;
  logic [2*DATA_WIDTH-1:0] product;
  logic [2*DATA_WIDTH-1:0] product_fix;
  logic [DATA_WIDTH-1:0] res_hi;
  logic [DATA_WIDTH-1:0] res_lo;

  // Decode an op request; a same-cycle flush cancels it entirely
  always_comb begin
    start_mul = 1'b0;
    start_div = 1'b0;
    signed_op = 1'b0;
    write_hi  = 1'b0;
    write_lo  = 1'b0;
    if (i_start && !i_flush) begin
      case (i_op)
        OP_MULT: begin
          start_mul = 1'b1;
          signed_op = 1'b1;
        end
        OP_MULTU: start_mul = 1'b1;
`ifdef MDU_DIV_EN
        OP_DIV: begin
          start_div = 1'b1;
          signed_op = 1'b1;
        end
        OP_DIVU: start_div = 1'b1;
`endif
        OP_MTHI: write_hi = 1'b1;
        OP_MTLO: write_lo = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand magnitudes: signed ops iterate on absolute values
  always_comb begin
    rs_mag = (signed_op && i_rs_data[DATA_WIDTH-1]) ? -i_rs_data : i_rs_data;
    rt_mag = (signed_op && i_rt_data[DATA_WIDTH-1]) ? -i_rt_data : i_rt_data;
  end

  mdu_iter_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
`ifdef MDU_DIV_EN
    .is_div  (op_div),
`endif
    .hi      (acc_hi),
    .lo      (acc_lo),
    .operand (operand_b),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // Sign fix-up of the finished magnitude result, plus the divide special cases.
  // The 0x80000000 / -1 overflow needs no extra logic: its magnitude quotient
  // 0x80000000 negates to itself and the remainder is zero.
  always_comb begin
    product     = {acc_hi, acc_lo};
    product_fix = res_neg ? -product : product;
    res_hi      = product_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    res_lo      = product_fix[DATA_WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (op_div) begin
      if (div_zero) begin
        res_hi = rs_orig;
        res_lo = DATA_WIDTH'(MDU_DIVZERO_LO);
      end else begin
        res_lo = res_neg ? -acc_lo : acc_lo;
        res_hi = rem_neg ? -acc_hi : acc_hi;
      end
    end
`endif
  end

  // Control FSM, iteration datapath and the architectural HI/LO registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      iter_cnt  <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      res_neg   <= 1'b0;
`ifdef MDU_DIV_EN
      op_div    <= 1'b0;
      rem_neg   <= 1'b0;
      div_zero  <= 1'b0;
      rs_orig   <= '0;
`endif
      o_hi      <= '0;
      o_lo      <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (write_hi) o_hi <= i_rs_data;
          if (write_lo) o_lo <= i_rs_data;
          if (start_mul || start_div) begin
            state     <= ST_CALC;
            o_busy    <= 1'b1;
            iter_cnt  <= '0;
            acc_hi    <= '0;
            acc_lo    <= start_div ? rs_mag : rt_mag;
            operand_b <= start_div ? rt_mag : rs_mag;
            res_neg   <= signed_op & (i_rs_data[DATA_WIDTH-1] ^ i_rt_data[DATA_WIDTH-1]);
`ifdef MDU_DIV_EN
            op_div    <= start_div;
            rem_neg   <= signed_op & i_rs_data[DATA_WIDTH-1];
            div_zero  <= (i_rt_data == '0);
            rs_orig   <= i_rs_data;
`endif
          end
        end
        ST_CALC: begin
          if (i_flush) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            acc_hi   <= step_hi;
            acc_lo   <= step_lo;
            iter_cnt <= iter_cnt + CNT_W'(1);
            if (iter_cnt == LAST_ITER) state <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
          if (!i_flush) begin
            o_hi   <= res_hi;
            o_lo   <= res_lo;
            o_done <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the EX stage, alongside the ALU. It consumes the rs/rt operands after the forwarding muxes have applied their selections. It executes MULT/MULTU/DIV/DIVU over many cycles into architectural HI/LO registers, and handles MTHI/MTLO in a single cycle. It drives `o_busy` to the hazard unit so that the ID stage stalls dependent MFHI/MFLO and further MDU ops.

## Interface
- `DATA_WIDTH`, 32: operand/HI/LO width; iteration count equals DATA_WIDTH.
- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  op request, sampled only in IDLE.
- `i_op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- `i_rs_data`  in  DATA_WIDTH  forwarded operand A (multiplicand/dividend/MTxx source).
- `i_rt_data`  in  DATA_WIDTH  forwarded operand B (multiplier/divisor).
- `i_flush`  in  1  abort in-flight op (branch mispredict/exception).
- `o_busy`  out  1  high in CALC and SIGN.
- `o_done`  out  1  one-cycle pulse when HI/LO hold a new MULT/DIV result.
- `o_hi`  out  DATA_WIDTH  HI register.
- `o_lo`  out  DATA_WIDTH  LO register.

## Operation
- Reset: state IDLE, `o_hi` = `o_lo` = 0, `o_busy` = 0, `o_done` = 0, iteration counter 0.
- FSM has three states:
  - IDLE → CALC on `i_start` with MULT/MULTU/DIV/DIVU. Latches operands, computes magnitudes for signed ops, and records the result signs.
  - CALC: one iteration per cycle.
    - Multiply is shift-add, one multiplier bit per cycle, into a 2×DATA_WIDTH accumulator.
    - Divide is restoring, one quotient bit per cycle.
    - After DATA_WIDTH iterations → SIGN.
  - SIGN: applies the sign fix, writes HI/LO, → IDLE.
- Sign rules:
  - Product is negated when operand signs differ.
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
  - HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero (signed or unsigned) bypasses the sign fix: HI = original `i_rs_data`, LO = 32'hFFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO in IDLE: writes `i_rs_data` to HI/LO at the next edge. State stays IDLE; no busy, no done.
- `i_start` while busy is ignored; the hazard unit guarantees it does not occur.
- `i_flush`:
  - In CALC/SIGN: IDLE next cycle, HI/LO unchanged, no `o_done`.
  - In IDLE: overrides a same-cycle `i_start`, including MTHI/MTLO, and no write occurs.
- `i_reset` has priority over `i_flush` and `i_start`. Mid-operation reset returns everything to reset values.

## Timing
- Cycle 0: `i_start` sampled in IDLE.
- Cycles 1..32: CALC, `o_busy` = 1.
- Cycle 33: SIGN, `o_busy` = 1.
- Cycle 34: IDLE, new `o_hi`/`o_lo` visible, `o_done` = 1 for this cycle only, `o_busy` = 0. A new `i_start` is accepted in cycle 34.
- MTHI/MTLO: value visible in cycle 1.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are supported as above.
- `MDU_DIV_EN` undefined:
  - Divider datapath is removed.
  - DIV/DIVU starts are treated as ignored ops: state stays IDLE, no busy, no done, HI/LO unchanged.
  - Multiply and MTxx behaviour is unchanged.

## Structure
- Shared package `mips_pkg`:
  - `mdu_op_t` op encodings.
  - FSM state enum (IDLE/CALC/SIGN).
  - `MDU_DIVZERO_LO` constant (all ones).
- One sub-module, `mdu_iter_step`: combinational single iteration. For multiply it performs a conditional add and shift; for divide, a trial subtract and restore. The top holds the FSM, counter, sign bookkeeping and HI/LO.

## Test plan
- MULT rs = −3 (0xFFFFFFFD), rt = 7 → cycle 34: HI = 0xFFFFFFFF, LO = 0xFFFFFFEB, `o_done` one-cycle pulse, `o_busy` high cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV −7 / 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 100 / 0 → HI = 100, LO = 0xFFFFFFFF. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- MTHI 0x12345678 then MTLO 0xCAFEBABE on consecutive cycles → HI/LO update one cycle each, `o_busy`/`o_done` stay 0.
- Start MULT with HI = LO = 5 loaded, assert `i_flush` at cycle 10 → IDLE at cycle 11, HI = LO = 5, no `o_done`. Repeat with `i_reset` at cycle 10 → HI = LO = 0 at cycle 11.
- Build without `MDU_DIV_EN`, issue DIV → `o_busy` stays 0, no `o_done`, HI/LO unchanged; a following MULT completes normally.
